// File: rtl/player2_bot.sv
// Autonomous player-2 controller: one decision per synchronised game tick, registered buttons.
// Optional LFSR jitter is enabled by defining BOT_JITTER_EN.
module player2_bot #(
  parameter int unsigned ATTACK_RANGE   = 12,
  parameter int unsigned ATTACK_HOLD    = 2,
  parameter int unsigned RETREAT_TICKS  = 4,
  parameter int unsigned COOLDOWN_TICKS = 3,
  parameter int unsigned X_MAX          = 95,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic       i_clk,
  input  logic       i_resn,
  input  logic       i_game_tick,
  input  logic       i_enable,
  input  logic [6:0] i_self_x,
  input  logic [6:0] i_self_y,
  input  logic [6:0] i_opp_x,
  input  logic [6:0] i_opp_y,
  input  logic [1:0] i_opp_combo,
  output logic       o_up_btn,
  output logic       o_down_btn,
  output logic       o_left_btn,
  output logic       o_right_btn,
  output logic       o_attack_btn,
  output logic [2:0] o_bot_state
);

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StApproach = 3'd1,
    StAttack   = 3'd2,
    StJump     = 3'd3,
    StRetreat  = 3'd4,
    StCooldown = 3'd5
  } state_e;

  localparam logic [6:0] RangeX      = 7'(ATTACK_RANGE);
  localparam logic [6:0] XMax        = 7'(X_MAX);
  localparam logic [3:0] AttackHold  = 4'(ATTACK_HOLD);
  localparam logic [3:0] RetreatLen  = 4'(RETREAT_TICKS);
  localparam logic [4:0] CooldownLen = 5'(COOLDOWN_TICKS);

  // Tick synchroniser and rising-edge detector
  logic [1:0] r_sync;
  logic       r_sync_q;
  logic       r_tick;

  always_ff @(posedge i_clk or negedge i_resn) begin
    if (!i_resn) begin
      r_sync   <= 2'b00;
      r_sync_q <= 1'b0;
      r_tick   <= 1'b0;
    end else begin
      r_sync   <= {r_sync[0], i_game_tick};
      r_sync_q <= r_sync[1];
      r_tick   <= r_sync[1] & ~r_sync_q;
    end
  end

  // Geometry
  logic       w_toward_right;
  logic [6:0] w_dist;
  logic       w_near;
  logic       w_entry_wall;
  logic       w_at_wall;
  logic       r_away_right;

  assign w_toward_right = (i_opp_x >= i_self_x);
  assign w_dist         = w_toward_right ? (i_opp_x - i_self_x) : (i_self_x - i_opp_x);
  assign w_near         = (w_dist <= RangeX);
  assign w_entry_wall   = w_toward_right ? (i_self_x == 7'd0) : (i_self_x >= XMax);
  assign w_at_wall      = r_away_right ? (i_self_x >= XMax) : (i_self_x == 7'd0);

  logic w_rnd_retreat;
  logic w_rnd_jump;
  logic w_rnd_ext;

`ifdef BOT_JITTER_EN
  localparam logic [15:0] LfsrInit = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

  logic [15:0] r_lfsr;
  logic        w_fb;

  assign w_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

  always_ff @(posedge i_clk or negedge i_resn) begin
    if (!i_resn) begin
      r_lfsr <= LfsrInit;
    end else if (i_enable && r_tick) begin
      r_lfsr <= {r_lfsr[14:0], w_fb};
    end
  end

  assign w_rnd_retreat = r_lfsr[2];
  assign w_rnd_jump    = (r_lfsr[1:0] == 2'b00);
  assign w_rnd_ext     = r_lfsr[0];
`else
  logic w_unused;

  assign w_rnd_retreat = 1'b1;
  assign w_rnd_jump    = 1'b0;
  assign w_rnd_ext     = 1'b0;
  assign w_unused      = ^{LFSR_SEED, 1'b0};
`endif

  logic w_unused_y;
  assign w_unused_y = ^{i_self_y, i_opp_y};

  // Cooldown length saturates so a 15-tick base plus jitter still fits the counter
  logic [4:0] w_cd_sum;
  logic [3:0] w_cd_len;

  assign w_cd_sum = CooldownLen + {4'b0000, w_rnd_ext};
  assign w_cd_len = (w_cd_sum > 5'd15) ? 4'd15 : w_cd_sum[3:0];

  state_e     r_state;
  logic [3:0] r_cnt;
  logic       r_up;
  logic       r_left;
  logic       r_right;
  logic       r_attack;

  always_ff @(posedge i_clk or negedge i_resn) begin
    if (!i_resn) begin
      r_state      <= StIdle;
      r_cnt        <= 4'd0;
      r_up         <= 1'b0;
      r_left       <= 1'b0;
      r_right      <= 1'b0;
      r_attack     <= 1'b0;
      r_away_right <= 1'b0;
    end else if (!i_enable) begin
      r_state  <= StIdle;
      r_cnt    <= 4'd0;
      r_up     <= 1'b0;
      r_left   <= 1'b0;
      r_right  <= 1'b0;
      r_attack <= 1'b0;
    end else if (r_tick) begin
      r_up     <= 1'b0;
      r_left   <= 1'b0;
      r_right  <= 1'b0;
      r_attack <= 1'b0;
      unique case (r_state)
        StIdle: begin
          r_state <= StApproach;
        end
        StApproach: begin
          if (w_near && (i_opp_combo != 2'b00) && w_rnd_retreat) begin
            r_state      <= StRetreat;
            r_cnt        <= RetreatLen;
            r_away_right <= ~w_toward_right;
            r_left       <= w_toward_right & ~w_entry_wall;
            r_right      <= ~w_toward_right & ~w_entry_wall;
          end else if (w_near && w_rnd_jump) begin
            r_state <= StJump;
            r_up    <= 1'b1;
            r_right <= w_toward_right;
            r_left  <= ~w_toward_right;
          end else if (w_near) begin
            r_state  <= StAttack;
            r_cnt    <= AttackHold;
            r_attack <= 1'b1;
          end else begin
            r_right <= w_toward_right;
            r_left  <= ~w_toward_right;
          end
        end
        StAttack: begin
          if (r_cnt <= 4'd1) begin
            r_state <= StCooldown;
            r_cnt   <= w_cd_len;
          end else begin
            r_cnt    <= r_cnt - 4'd1;
            r_attack <= 1'b1;
          end
        end
        StJump: begin
          r_state <= StCooldown;
          r_cnt   <= w_cd_len;
        end
        StRetreat: begin
          if (w_at_wall || (r_cnt <= 4'd1)) begin
            r_state <= StCooldown;
            r_cnt   <= w_cd_len;
          end else begin
            r_cnt   <= r_cnt - 4'd1;
            r_left  <= ~r_away_right;
            r_right <= r_away_right;
          end
        end
        StCooldown: begin
          if (r_cnt <= 4'd1) begin
            r_state <= StApproach;
            r_cnt   <= 4'd0;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: begin
          r_state <= StIdle;
          r_cnt   <= 4'd0;
        end
      endcase
    end
  end

  assign o_up_btn     = r_up;
  assign o_down_btn   = 1'b0;
  assign o_left_btn   = r_left;
  assign o_right_btn  = r_right;
  assign o_attack_btn = r_attack;
  assign o_bot_state  = r_state;

endmodule

// File: tb/tb_player2_bot.sv
// Self-checking bench for player2_bot: tick-level behavioural model plus directed literal checks.
// Jitter-specific checks are built when BOT_JITTER_EN is defined.
module tb_player2_bot;

  localparam int AttackRange = 12;
  localparam int AttackHold  = 2;
  localparam int RetreatLen  = 4;
  localparam int CooldownLen = 3;
  localparam int XMax        = 95;

  logic       clk = 1'b0;
  logic       resn;
  logic       game_tick;
  logic       enable;
  logic [6:0] self_x, self_y, opp_x, opp_y;
  logic [1:0] opp_combo;
  logic       up_btn, down_btn, left_btn, right_btn, attack_btn;
  logic [2:0] bot_state;

  always #5 clk = ~clk;

  player2_bot dut (
    .i_clk       (clk),
    .i_resn      (resn),
    .i_game_tick (game_tick),
    .i_enable    (enable),
    .i_self_x    (self_x),
    .i_self_y    (self_y),
    .i_opp_x     (opp_x),
    .i_opp_y     (opp_y),
    .i_opp_combo (opp_combo),
    .o_up_btn    (up_btn),
    .o_down_btn  (down_btn),
    .o_left_btn  (left_btn),
    .o_right_btn (right_btn),
    .o_attack_btn(attack_btn),
    .o_bot_state (bot_state)
  );

  int n_chk = 0;
  int n_err = 0;

  // Model: phase plus ticks elapsed in that phase
  int          m_state, m_el, m_cd_len;
  bit          m_away_right;
  bit          m_up, m_left, m_right, m_atk;
  logic [15:0] m_lfsr;
  bit          cmp_on = 0;

  task automatic model_reset();
    m_state = 0; m_el = 0; m_cd_len = 0; m_away_right = 0;
    m_up = 0; m_left = 0; m_right = 0; m_atk = 0;
    m_lfsr = 16'hACE1;
  endtask

  task automatic model_idle();
    m_state = 0; m_el = 0;
    m_up = 0; m_left = 0; m_right = 0; m_atk = 0;
  endtask

  task automatic enter(input int s);
    m_state = s;
    m_el    = 1;
  endtask

  task automatic model_tick();
    int d;
    bit tr, near, r2, rj, r0, wall;
    logic fb;
    if (!enable) return;
    tr   = (opp_x >= self_x);
    d    = tr ? int'(opp_x) - int'(self_x) : int'(self_x) - int'(opp_x);
    near = (d <= AttackRange);
`ifdef BOT_JITTER_EN
    r2 = m_lfsr[2]; rj = (m_lfsr[1:0] == 2'b00); r0 = m_lfsr[0];
`else
    r2 = 1; rj = 0; r0 = 0;
`endif
    m_up = 0; m_left = 0; m_right = 0; m_atk = 0;
    case (m_state)
      0: enter(1);
      1: begin
        if (near && opp_combo != 0 && r2) begin
          enter(4);
          m_away_right = !tr;
          wall = tr ? (self_x == 0) : (self_x >= XMax);
          if (!wall) begin m_left = tr; m_right = !tr; end
        end else if (near && rj) begin
          enter(3); m_up = 1; m_right = tr; m_left = !tr;
        end else if (near) begin
          enter(2); m_atk = 1;
        end else begin
          m_right = tr; m_left = !tr;
        end
      end
      2: begin
        if (m_el >= AttackHold) begin enter(5); m_cd_len = CooldownLen + int'(r0); end
        else begin m_el++; m_atk = 1; end
      end
      3: begin enter(5); m_cd_len = CooldownLen + int'(r0); end
      4: begin
        wall = m_away_right ? (self_x >= XMax) : (self_x == 0);
        if (wall || m_el >= RetreatLen) begin enter(5); m_cd_len = CooldownLen + int'(r0); end
        else begin m_el++; m_left = !m_away_right; m_right = m_away_right; end
      end
      5: begin
        if (m_el >= m_cd_len) enter(1);
        else m_el++;
      end
      default: model_idle();
    endcase
    fb = m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10];
    m_lfsr = {m_lfsr[14:0], fb};
  endtask

  always @(negedge clk) begin
    logic [7:0] act, exp;
    if (cmp_on) begin
      act = {bot_state, up_btn, down_btn, left_btn, right_btn, attack_btn};
      exp = {3'(m_state), m_up, 1'b0, m_left, m_right, m_atk};
      n_chk++;
      if (act !== exp) begin
        n_err++;
        $display("FAIL model t=%0t got {st,u,d,l,r,a}=%b expected %b", $time, act, exp);
      end
      n_chk++;
      if (left_btn && right_btn) begin
        n_err++;
        $display("FAIL left_right_exclusive t=%0t got both=1 expected not both", $time);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_tick(input bit lat = 0);
    @(negedge clk); game_tick = 1'b1;
    repeat (3) @(posedge clk);
    if (lat) begin #1; chk("lat_edge3_right", int'(right_btn), 0); end
    @(posedge clk); model_tick();
    if (lat) begin
      #1;
      chk("lat_edge4_right", int'(right_btn), 1);
      chk("lat_edge4_left", int'(left_btn), 0);
    end
    @(negedge clk); game_tick = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic set_enable(input bit v);
    @(negedge clk); enable = v;
    @(posedge clk);
    if (!v) model_idle();
    #1;
  endtask

  initial begin
    int cd_run;
    bit seen_jump, seen_atk;
    int off, ox;
    resn = 0; enable = 0; game_tick = 0;
    self_x = 10; self_y = 20; opp_x = 60; opp_y = 20; opp_combo = 0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_state", int'(bot_state), 0);
    chk("rst_buttons", int'({up_btn, down_btn, left_btn, right_btn, attack_btn}), 0);
    cmp_on = 1;
    @(negedge clk); resn = 1;

    repeat (5) do_tick();
    chk("disabled_state", int'(bot_state), 0);
    chk("disabled_buttons", int'({up_btn, left_btn, right_btn, attack_btn}), 0);

    // Approach: far opponent on the right
    set_enable(1);
    do_tick();
    chk("approach_state", int'(bot_state), 1);
    chk("approach_entry_right", int'(right_btn), 0);
    do_tick(1);
    chk("approach_hold_state", int'(bot_state), 1);

`ifndef BOT_JITTER_EN
    // Attack then cooldown
    self_x = 50; opp_x = 55;
    do_tick();
    chk("attack1_state", int'(bot_state), 2);
    chk("attack1_btn", int'(attack_btn), 1);
    do_tick();
    chk("attack2_btn", int'(attack_btn), 1);
    do_tick();
    chk("cool1_state", int'(bot_state), 5);
    chk("cool1_btn", int'(attack_btn), 0);
    do_tick(); do_tick();
    chk("cool3_state", int'(bot_state), 5);
    do_tick();
    chk("after_cool_state", int'(bot_state), 1);
    do_tick();
    chk("attack_again_state", int'(bot_state), 2);
    set_enable(0);
    chk("en_drop_state", int'(bot_state), 0);
    chk("en_drop_attack", int'(attack_btn), 0);

    // Retreat towards the left wall
    self_x = 2; opp_x = 8; opp_combo = 1;
    set_enable(1);
    do_tick();
    do_tick();
    chk("retreat_state", int'(bot_state), 4);
    chk("retreat_left", int'(left_btn), 1);
    chk("retreat_right", int'(right_btn), 0);
    do_tick();
    chk("retreat2_left", int'(left_btn), 1);
    self_x = 0;
    do_tick();
    chk("wall_state", int'(bot_state), 5);
    chk("wall_left", int'(left_btn), 0);

    // Asynchronous reset in the middle of an attack
    opp_combo = 0; self_x = 50; opp_x = 55;
    for (int i = 0; i < 10 && m_state != 2; i++) do_tick();
    chk("pre_reset_state", int'(bot_state), 2);
    @(negedge clk); #2 resn = 0; model_reset();
    #1;
    chk("async_rst_state", int'(bot_state), 0);
    chk("async_rst_attack", int'(attack_btn), 0);
    @(negedge clk); resn = 1;
    do_tick();
    chk("post_rst_state", int'(bot_state), 1);
`endif

    // Mixed run against the model
    set_enable(0);
    set_enable(1);
    cd_run = 0; seen_jump = 0; seen_atk = 0;
`ifdef BOT_JITTER_EN
    for (int i = 0; i < 200; i++) begin
`else
    for (int i = 0; i < 60; i++) begin
`endif
      if (i % 3 == 0) begin
        self_x = 7'($urandom_range(0, XMax));
        off    = int'($urandom_range(0, 40)) - 20;
        ox     = int'(self_x) + off;
        if (ox < 0) ox = 0;
        if (ox > XMax) ox = XMax;
        opp_x  = 7'(ox);
      end
      opp_combo = 2'($urandom_range(0, 3));
      do_tick();
      if (bot_state == 3'd3) seen_jump = 1;
      if (bot_state == 3'd2) seen_atk = 1;
      if (bot_state == 3'd5) cd_run++;
      else if (cd_run > 0) begin
        n_chk++;
        if (cd_run != 3 && cd_run != 4) begin
          n_err++;
          $display("FAIL cooldown_len: got %0d ticks expected 3 or 4", cd_run);
        end
        cd_run = 0;
      end
    end
`ifdef BOT_JITTER_EN
    chk("jitter_seen_jump", int'(seen_jump), 1);
    chk("jitter_seen_attack", int'(seen_atk), 1);
`endif

    cmp_on = 0;
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
